// File: rtl/result_streamer.sv
// rtl/result_streamer.sv - float estimate to saturated fixed point converter with output FIFO (optional RESULT_DROPCNT_EN adds drop_cnt)
module result_streamer #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [EXP_W+MANT_W:0] in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  full,
    output logic                  sat
`ifdef RESULT_DROPCNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;
    localparam int SH_W   = EXP_W + 8;
    localparam int WIDE_W = MANT_W + 1 + OUT_W;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

    // Shift applied to the integer mantissa {1,m}: e - bias + frac - mant
    localparam logic signed [SH_W-1:0] SH_OFF = SH_W'(FRAC_W - MANT_W - BIAS);
    // Any left shift of at least OUT_W pushes the leading one past the sign bit
    localparam logic signed [SH_W-1:0] SH_MAX = SH_W'(OUT_W);
    // Right shifts beyond MANT_W+1 leave neither integer bits nor a round bit
    localparam logic [SH_W-1:0]        RS_MAX = SH_W'(MANT_W + 1);
    localparam logic [SH_W-1:0]        RS_ONE = SH_W'(1);
    localparam logic [WIDE_W-1:0]      LIM    = WIDE_W'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0]       POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]       NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        TAG_ZERO,
        TAG_NORM,
        TAG_SPEC
    } tag_t;

    logic                  in_sign;
    logic [EXP_W-1:0]      in_exp;
    logic [MANT_W-1:0]     in_mant;

    assign in_sign = in[EXP_W+MANT_W];
    assign in_exp  = in[EXP_W+MANT_W-1:MANT_W];
    assign in_mant = in[MANT_W-1:0];

    // Stage 1 registers
    logic                   s1_valid;
    logic                   s1_sign;
    logic [MANT_W-1:0]      s1_mant;
    logic signed [SH_W-1:0] s1_shift;
    tag_t                   s1_tag;

    // Stage 2 registers
    logic                   s2_valid;
    logic [OUT_W-1:0]       s2_data;
    logic                   s2_sat;

    // Conversion datapath
    logic [MANT_W:0]        mant_full;
    logic [SH_W-1:0]        rs;
    logic [WIDE_W-1:0]      mag;
    logic [WIDE_W-1:0]      rnd;
    logic                   over;
    logic [OUT_W-1:0]       conv_data;
    logic                   conv_sat;

    // FIFO
    logic [OUT_W-1:0]       mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr_n;
    logic [PW-1:0]          rd_ptr_n;
    logic                   rd_en;
    logic                   wr_en;

    // S1: decode sign, unbiased shift and special-case class of the incoming float
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= in_sign;
                s1_mant  <= in_mant;
                s1_shift <= $signed(SH_W'(in_exp)) + SH_OFF;
                if (in_exp == '0) begin
                    s1_tag <= TAG_ZERO;
                end else if (&in_exp) begin
                    s1_tag <= TAG_SPEC;
                end else begin
                    s1_tag <= TAG_NORM;
                end
            end
        end
    end

    // Shift the mantissa into place, round half away from zero, then saturate and apply sign
    always_comb begin
        mant_full = {1'b1, s1_mant};
        rs        = -s1_shift;
        mag       = '0;
        rnd       = '0;
        over      = 1'b0;
        case (s1_tag)
            TAG_ZERO: mag = '0;
            TAG_SPEC: over = 1'b1;
            default: begin
                if (!s1_shift[SH_W-1]) begin
                    if (s1_shift >= SH_MAX) begin
                        over = 1'b1;
                    end else begin
                        mag = WIDE_W'(mant_full) << s1_shift;
                    end
                end else if (rs <= RS_MAX) begin
                    // Keep one extra bit below the LSB; it is the half-LSB round bit
                    rnd = WIDE_W'(mant_full) >> (rs - RS_ONE);
                    mag = (rnd >> 1) + WIDE_W'(rnd[0]);
                end
            end
        endcase
        // The negative range reaches one step further than the positive range
        if (!over) begin
            over = s1_sign ? (mag > LIM) : (mag >= LIM);
        end
        if (over) begin
            conv_data = s1_sign ? NEG_MAX : POS_MAX;
        end else begin
            conv_data = s1_sign ? (-mag[OUT_W-1:0]) : mag[OUT_W-1:0];
        end
        conv_sat = over;
    end

    // S2: hold the converted word until it is offered to the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= conv_data;
                s2_sat  <= conv_sat;
            end
        end
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign rd_en    = out_valid && out_ready;
    assign wr_en    = s2_valid && (!full || rd_en);
    assign wr_ptr_n = wr_ptr + PW'(wr_en);
    assign rd_ptr_n = rd_ptr + PW'(rd_en);

    // FIFO storage write; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr[AW-1:0]] <= s2_data;
        end
    end

    // Pointers, registered status flags and the head register, all reflecting post-edge occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
            out_data  <= '0;
            sat       <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            out_valid <= (wr_ptr_n != rd_ptr_n);
            full      <= (wr_ptr_n == {~rd_ptr_n[AW], rd_ptr_n[AW-1:0]});
            // Bypass the array when the new head is the word being written this edge
            if (wr_ptr_n != rd_ptr_n) begin
                out_data <= (wr_en && (wr_ptr == rd_ptr_n)) ? s2_data
                                                            : mem[rd_ptr_n[AW-1:0]];
            end
            if (s2_valid && s2_sat) begin
                sat <= 1'b1;
            end
        end
    end

`ifdef RESULT_DROPCNT_EN
    logic drop;

    assign drop = s2_valid && full && !rd_en;

    // Saturating count of samples lost to a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_result_streamer.sv
// tb/tb_result_streamer.sv - directed table-driven bench for result_streamer
module tb_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_bits;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        full;
    logic        sat;
`ifdef RESULT_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] in_bits;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    localparam int NV = 15;
    vec_t        vecs [NV];
    logic [31:0] bp_in  [6];
    logic [15:0] bp_exp [6];

    always #5 clk = ~clk;

    result_streamer #(
        .EXP_W (8),
        .MANT_W(23),
        .OUT_W (16),
        .FRAC_W(8),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in       (in_bits),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .full     (full),
        .sat      (sat)
`ifdef RESULT_DROPCNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h3FC00000, 16'h0180, 1'b0};
        vecs[1]  = '{32'hC0100000, 16'hFDC0, 1'b0};
        vecs[2]  = '{32'h00000000, 16'h0000, 1'b0};
        vecs[3]  = '{32'h3B000000, 16'h0001, 1'b0};
        vecs[4]  = '{32'hBB000000, 16'hFFFF, 1'b0};
        vecs[5]  = '{32'h3A800000, 16'h0000, 1'b0};
        vecs[6]  = '{32'h00000001, 16'h0000, 1'b0};
        vecs[7]  = '{32'h42FFFE00, 16'h7FFF, 1'b0};
        vecs[8]  = '{32'h43480000, 16'h7FFF, 1'b1};
        vecs[9]  = '{32'hC3000000, 16'h8000, 1'b1};
        vecs[10] = '{32'hC3960000, 16'h8000, 1'b1};
        vecs[11] = '{32'h7F800000, 16'h7FFF, 1'b1};
        vecs[12] = '{32'h42FFFF00, 16'h7FFF, 1'b1};
        vecs[13] = '{32'h7FC00000, 16'h7FFF, 1'b1};
        vecs[14] = '{32'hFF800000, 16'h8000, 1'b1};

        bp_in[0] = 32'h3F800000; bp_exp[0] = 16'h0100;
        bp_in[1] = 32'h40000000; bp_exp[1] = 16'h0200;
        bp_in[2] = 32'h40400000; bp_exp[2] = 16'h0300;
        bp_in[3] = 32'h40800000; bp_exp[3] = 16'h0400;
        bp_in[4] = 32'h40A00000; bp_exp[4] = 16'h0500;
        bp_in[5] = 32'h40C00000; bp_exp[5] = 16'h0600;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bits   = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_full",      32'(full),      32'd0);
        check("rst_sat",       32'(sat),       32'd0);
        rst = 1'b0;

        // Conversion, rounding and saturation table with exact two-edge latency
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_bits  = vecs[i].in_bits;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_valid_e1", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_valid_e2", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_data", i),     32'(out_data),  32'(vecs[i].exp_data));
            check($sformatf("v%0d_sat", i),      32'(sat),       32'(vecs[i].exp_sat));
            @(negedge clk);
            check($sformatf("v%0d_popped", i),   32'(out_valid), 32'd0);
        end

        // Backpressure: six pushes into four entries
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("bp_not_full_at3", 32'(full), 32'd0);
            in_bits  = bp_in[i];
            in_valid = 1'b1;
            @(negedge clk);
        end
        check("bp_full_at4", 32'(full), 32'd1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_full_held", 32'(full),      32'd1);
        check("bp_valid",     32'(out_valid), 32'd1);
        check("bp_head",      32'(out_data),  32'(bp_exp[0]));
`ifdef RESULT_DROPCNT_EN
        check("bp_drop_cnt",  32'(drop_cnt),  32'd2);
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_drain%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_drain%0d_data", k),  32'(out_data),  32'(bp_exp[k]));
            @(negedge clk);
        end
        check("bp_empty_valid", 32'(out_valid), 32'd0);
        check("bp_empty_full",  32'(full),      32'd0);
        @(negedge clk);
        check("bp_no_underflow", 32'(out_valid), 32'd0);

        // Full FIFO with a read on the same edge as the fifth write
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_bits  = bp_in[i];
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("fr_full_before", 32'(full), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("fr_full_after", 32'(full),     32'd1);
        check("fr_head",       32'(out_data), 32'(bp_exp[1]));
`ifdef RESULT_DROPCNT_EN
        check("fr_drop_cnt",   32'(drop_cnt), 32'd0);
`endif
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check($sformatf("fr_drain%0d_data", k), 32'(out_data), 32'(bp_exp[k]));
            @(negedge clk);
        end
        check("fr_empty_valid", 32'(out_valid), 32'd0);

        // Mid-stream reset with three buffered samples, one saturated
        do_reset();
        in_bits = 32'h43480000; in_valid = 1'b1; @(negedge clk);
        in_bits = 32'h3FC00000;                  @(negedge clk);
        in_bits = 32'hC0100000;                  @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_sat_before",   32'(sat),       32'd1);
        check("mr_valid_before", 32'(out_valid), 32'd1);
        check("mr_head_before",  32'(out_data),  32'h7FFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_valid_after", 32'(out_valid), 32'd0);
        check("mr_sat_after",   32'(sat),       32'd0);
        check("mr_full_after",  32'(full),      32'd0);
        out_ready = 1'b1;
        in_bits   = 32'h3FC00000;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mr_post_e1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("mr_post_e2_valid", 32'(out_valid), 32'd1);
        check("mr_post_e2_data",  32'(out_data),  32'h0180);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
